// File: rtl/dest_reader.sv
// Drain-side reader for destination FIFOs D0/D1.
// Each lane pops its FIFO independently, absorbs the one-cycle FIFO read latency
// in a 2-entry skid buffer and presents a valid/ready stream.
// Optional feature: define DEST_READER_COUNT_EN to build the delivered-word counters;
// otherwise count0/count1 are tied to zero.
module dest_reader #(
  parameter int unsigned DATA_SIZE  = 6,
  parameter int unsigned COUNT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  active_in,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic [DATA_SIZE-1:0]  data_in0,
  input  logic [DATA_SIZE-1:0]  data_in1,
  input  logic                  ready0,
  input  logic                  ready1,
  output logic                  pop0,
  output logic                  pop1,
  output logic [DATA_SIZE-1:0]  data_out0,
  output logic [DATA_SIZE-1:0]  data_out1,
  output logic                  valid_out0,
  output logic                  valid_out1,
  output logic [COUNT_SIZE-1:0] count0,
  output logic [COUNT_SIZE-1:0] count1,
  output logic                  idle_out
);

  logic                 empty     [2];
  logic                 ready     [2];
  logic [DATA_SIZE-1:0] din       [2];
  logic                 valid     [2];
  logic                 consume   [2];
  logic                 pop       [2];
  logic [2:0]           occ       [2];
  logic [1:0]           entries_q [2];
  logic [1:0]           entries_d [2];
  logic                 inflight_q[2];
  logic                 inflight_d[2];
  logic [DATA_SIZE-1:0] head_q    [2];
  logic [DATA_SIZE-1:0] head_d    [2];
  logic [DATA_SIZE-1:0] tail_q    [2];
  logic [DATA_SIZE-1:0] tail_d    [2];

  assign empty[0] = empty0;
  assign empty[1] = empty1;
  assign ready[0] = ready0;
  assign ready[1] = ready1;
  assign din[0]   = data_in0;
  assign din[1]   = data_in1;

  // Per-lane handshake, pop credit and skid-buffer next state.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      valid[k]      = !reset_L && (entries_q[k] != 2'd0);
      consume[k]    = valid[k] && ready[k];
      // Occupancy after this edge; consume is credited so pop can reassert immediately.
      occ[k]        = {1'b0, entries_q[k]} + {2'b00, inflight_q[k]} - {2'b00, consume[k]};
      pop[k]        = !reset_L && active_in && !empty[k] && (occ[k] < 3'd2);
      entries_d[k]  = occ[k][1:0];
      inflight_d[k] = pop[k];
      head_d[k]     = head_q[k];
      tail_d[k]     = tail_q[k];
      case (entries_q[k])
        2'd0: begin
          if (inflight_q[k]) head_d[k] = din[k];
        end
        2'd1: begin
          // Head leaves while the returning word arrives: the new word becomes the head.
          if (inflight_q[k]) begin
            if (consume[k]) head_d[k] = din[k];
            else            tail_d[k] = din[k];
          end
        end
        default: begin
          if (consume[k]) begin
            head_d[k] = tail_q[k];
            if (inflight_q[k]) tail_d[k] = din[k];
          end
        end
      endcase
    end
  end

  // Lane state registers; a word returning during reset is dropped with the rest.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_L) begin
        entries_q[k]  <= 2'd0;
        inflight_q[k] <= 1'b0;
        head_q[k]     <= '0;
        tail_q[k]     <= '0;
      end else begin
        entries_q[k]  <= entries_d[k];
        inflight_q[k] <= inflight_d[k];
        head_q[k]     <= head_d[k];
        tail_q[k]     <= tail_d[k];
      end
    end
  end

  assign pop0       = pop[0];
  assign pop1       = pop[1];
  assign valid_out0 = valid[0];
  assign valid_out1 = valid[1];
  assign data_out0  = reset_L ? '0 : head_q[0];
  assign data_out1  = reset_L ? '0 : head_q[1];
  assign idle_out   = empty0 && empty1 &&
                      (reset_L || ((entries_q[0] == 2'd0) && (entries_q[1] == 2'd0) &&
                                   !inflight_q[0] && !inflight_q[1]));

`ifdef DEST_READER_COUNT_EN
  logic [COUNT_SIZE-1:0] count_q[2];
  logic [COUNT_SIZE-1:0] count_d[2];

  // Delivered-word counters, wrapping naturally at 2^COUNT_SIZE.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      count_d[k] = consume[k] ? count_q[k] + COUNT_SIZE'(1) : count_q[k];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_L) count_q[k] <= '0;
      else         count_q[k] <= count_d[k];
    end
  end

  assign count0 = reset_L ? '0 : count_q[0];
  assign count1 = reset_L ? '0 : count_q[1];
`else
  assign count0 = '0;
  assign count1 = '0;
`endif

endmodule

// File: tb/tb_dest_reader.sv
// Bench for dest_reader: FIFO model, scoreboard queues and a monitor that checks
// every delivered word; directed sequences check timing and counters.
module tb_dest_reader;
  localparam int DW = 6;
  localparam int CW = 8;
`ifdef DEST_READER_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_L, active_in, empty0, empty1, ready0, ready1;
  logic [DW-1:0] data_in0, data_in1;
  logic          pop0, pop1, valid_out0, valid_out1, idle_out;
  logic [DW-1:0] data_out0, data_out1;
  logic [CW-1:0] count0, count1;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fifo0[$];
  logic [DW-1:0] fifo1[$];
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];

  always #5 clk = ~clk;

  dest_reader #(.DATA_SIZE(DW), .COUNT_SIZE(CW)) dut (
    .clk(clk), .reset_L(reset_L), .active_in(active_in),
    .empty0(empty0), .empty1(empty1), .data_in0(data_in0), .data_in1(data_in1),
    .ready0(ready0), .ready1(ready1), .pop0(pop0), .pop1(pop1),
    .data_out0(data_out0), .data_out1(data_out1),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .count0(count0), .count1(count1), .idle_out(idle_out)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [DW-1:0] w);
    fifo0.push_back(w);
    sb0.push_back(w);
    empty0 = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] w);
    fifo1.push_back(w);
    sb1.push_back(w);
    empty1 = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((sb0.size() + sb1.size()) != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, sb0.size() + sb1.size(), 0);
  endtask

  // FIFO model: a pop seen in cycle N returns its word just after the edge ending N.
  always begin
    bit p0, p1;
    @(negedge clk);
    p0 = pop0;
    p1 = pop1;
    chk("no_pop_when_empty0", pop0 & empty0, 0);
    chk("no_pop_when_empty1", pop1 & empty1, 0);
    @(posedge clk);
    #1;
    if (p0 && fifo0.size() > 0) data_in0 = fifo0.pop_front();
    if (p1 && fifo1.size() > 0) data_in1 = fifo1.pop_front();
    empty0 = (fifo0.size() == 0);
    empty1 = (fifo1.size() == 0);
  end

  // Monitor: every accepted word must match the scoreboard head.
  always @(negedge clk) begin
    if (valid_out0 && ready0) begin
      if (sb0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lane0_unexpected_word got=0x%0h required=none", data_out0);
      end else chk("lane0_data", data_out0, sb0.pop_front());
    end
    if (valid_out1 && ready1) begin
      if (sb1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lane1_unexpected_word got=0x%0h required=none", data_out1);
      end else chk("lane1_data", data_out1, sb1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int n;
    reset_L   = 1'b1;
    active_in = 1'b1;
    ready0    = 1'b1;
    ready1    = 1'b1;
    empty0    = 1'b1;
    empty1    = 1'b1;
    data_in0  = '0;
    data_in1  = '0;

    // Reset with three words in each FIFO, then lane 0 streaming 0x15/0x2A/0x3F.
    push0(6'h15); push0(6'h2A); push0(6'h3F);
    push1(6'h01); push1(6'h02); push1(6'h03);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_pop0", pop0, 0);
      chk("rst_pop1", pop1, 0);
      chk("rst_valid0", valid_out0, 0);
      chk("rst_valid1", valid_out1, 0);
      chk("rst_data0", data_out0, 0);
      chk("rst_data1", data_out1, 0);
      chk("rst_count0", count0, 0);
      chk("rst_count1", count1, 0);
      chk("rst_idle_fifos_full", idle_out, 0);
      tick();
    end
    reset_L = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stream_pop0", pop0, (c < 3) ? 1 : 0);
      chk("stream_pop1", pop1, (c < 3) ? 1 : 0);
      chk("stream_valid0", valid_out0, (c >= 2 && c < 5) ? 1 : 0);
      tick();
    end
    drain("stream_drain", 20);
    @(negedge clk);
    chk("stream_count0", count0, CountEn ? 3 : 0);
    chk("stream_count1", count1, CountEn ? 3 : 0);
    chk("idle_after_drain", idle_out, 1);
    tick();

    // Lane 1 backpressure: five words, sink stalled.
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) push1(6'h05 + 6'(i));
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pop1) n++;
      tick();
    end
    @(negedge clk);
    chk("bp_pop_count", n, 2);
    chk("bp_pop1_stopped", pop1, 0);
    chk("bp_valid1", valid_out1, 1);
    chk("bp_head", data_out1, 6'h05);
    tick();
    @(negedge clk);
    chk("bp_head_stable", data_out1, 6'h05);
    tick();
    ready1 = 1'b1;
    @(negedge clk);
    chk("bp_pop_on_ready", pop1, 1);
    repeat (4) tick();
    tick();
    ready1 = 1'b0;
    chk("bp_all_delivered", sb1.size(), 0);
    @(negedge clk);
    chk("bp_count1", count1, CountEn ? 8 : 0);
    tick();
    ready1 = 1'b1;

    // active_in drops right after a pop: in-flight word still delivered, no new pops.
    push0(6'h11); push0(6'h22);
    @(negedge clk);
    chk("act_first_pop", pop0, 1);
    tick();
    active_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("act_no_pop", pop0, 0);
      if (c == 1) begin
        chk("act_inflight_valid", valid_out0, 1);
        chk("act_inflight_data", data_out0, 6'h11);
      end
      tick();
    end
    active_in = 1'b1;
    @(negedge clk);
    chk("act_resume_pop", pop0, 1);
    drain("act_drain", 20);

    // Reset one cycle after a pop: returned word is discarded.
    push0(6'h33);
    @(negedge clk);
    chk("rp_pop", pop0, 1);
    tick();
    reset_L = 1'b1;
    sb0.delete();
    @(negedge clk);
    chk("rp_idle_in_reset", idle_out, 1);
    chk("rp_pop_in_reset", pop0, 0);
    chk("rp_valid_in_reset", valid_out0, 0);
    tick();
    reset_L = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rp_valid_after", valid_out0, 0);
      tick();
    end
    chk("rp_count0", count0, 0);
    chk("rp_count1", count1, 0);

    // 256 words through lane 0: counter wraps.
    for (int i = 0; i < 256; i++) push0(6'(i));
    seen = 1'b0;
    n = 0;
    while (sb0.size() != 0 && n < 400) begin
      tick();
      n++;
      if (sb0.size() == 1 && !seen) begin
        seen = 1'b1;
        chk("wrap_count_255", count0, CountEn ? 255 : 0);
      end
    end
    chk("wrap_drain", sb0.size(), 0);
    chk("wrap_seen_255", seen, 1);
    chk("wrap_count_0", count0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dest_reader.md
# dest_reader

Drain-side reader for the two destination FIFOs (D0, D1) at the output end of the switch datapath. It pops each destination FIFO independently whenever that FIFO holds data and the downstream sink has room, and absorbs the FIFO's one-cycle read latency in a per-lane 2-entry skid buffer. It presents each lane as a valid/ready stream and sustains one word per cycle per lane. It reports idle status back to the control FSM and counts delivered words.

## Interface
- DATA_SIZE, 6: word width of D0/D1 entries and of data_out0/data_out1.
- COUNT_SIZE, 8: width of per-lane delivered-word counters.
- clk  in  1  clock; all logic is rising-edge.
- reset_L  in  1  synchronous reset, active-high (1 = reset), sampled on rising clk.
- active_in  in  1  FSM active state; new pops are issued only while high.
- empty0, empty1  in  1  destination FIFO empty flags.
- data_in0, data_in1  in  DATA_SIZE  FIFO read data, valid the cycle after the matching pop.
- ready0, ready1  in  1  downstream sink accepts the word this cycle.
- pop0, pop1  out  1  FIFO read strobes.
- data_out0, data_out1  out  DATA_SIZE  head of lane buffer.
- valid_out0, valid_out1  out  1  lane buffer non-empty.
- count0, count1  out  COUNT_SIZE  delivered-word counters.
- idle_out  out  1  nothing buffered, nothing in flight, both FIFOs empty.

## Operation
- The two lanes are identical and fully independent. No arbitration is performed between them.
- Per-lane state:
  - entries_k: 0..2, buffer occupancy.
  - inflight_k: 1 bit, a pop was issued last cycle.
  - consume_k = valid_out_k & ready_k.
- pop_k = active_in & !empty_k & (entries_k + inflight_k - consume_k < 2). This is combinational from registered state and the current inputs.
- When inflight_k is set, data_in_k is written to the buffer tail on the clock edge.
- Buffer update per edge: entries_k += inflight_k - consume_k. A write and a read in the same cycle are legal.
- At entries = 1 with a same-cycle write and read, the new word becomes the head.
- data_out_k always shows the oldest word. It holds stable while valid_out_k is high and ready_k is low.
- A pop already in flight completes even if active_in drops. The word is buffered and delivered normally.
- count_k increments on each consume_k and wraps from 2^COUNT_SIZE-1 to 0.
- idle_out = (entries0|entries1|inflight0|inflight1)==0 & empty0 & empty1.

## Timing
- All outputs in the reset cycle and after reset:
  - pop0/1 = 0.
  - valid_out0/1 = 0.
  - data_out0/1 = 0.
  - count0/1 = 0.
  - idle_out = 1 only if both FIFOs are empty.
- Latency: pop at cycle N, data captured at the end of N+1, valid_out high in N+2. FIFO-to-sink latency is 2 cycles.
- Throughput: with ready held high, pop_k is high every cycle and valid_out_k is high every cycle from N+2 onward.
- Backpressure: with ready_k low, at most 2 words are buffered. pop_k stops once entries + inflight reaches 2, and no word is ever dropped.
- When ready_k rises with a full buffer, pop_k reasserts in the same cycle, because consume is credited.
- Empty FIFO: pop_k is never asserted while empty_k is high.
- Reset asserted mid-operation:
  - Buffers, inflight and counters are cleared.
  - A word returned by a pop issued in the cycle before reset is discarded.
  - pop_k stays 0 during every reset cycle.

## Configuration
- DEST_READER_COUNT_EN: when defined, count0/count1 are implemented as specified.
- When undefined, the counter registers are not built and count0/count1 are driven constant 0. The ports remain present.

## Test plan
- Reset with both FIFOs holding 3 words -> all outputs 0 during reset; after release with active_in=1, pop0/pop1 rise in the first cycle.
- Lane 0: FIFO holds 0x15, 0x2A, 0x3F with ready0=1 -> pop0 high for 3 cycles; valid_out0 high for 3 cycles starting 2 cycles after the first pop with data 0x15, 0x2A, 0x3F; count0 = 3.
- Lane 1 backpressure: 5 words with ready1=0 -> exactly 2 pops, entries=2, pop1 low; ready1 raised for 5 cycles -> all 5 words delivered in order, none lost.
- active_in dropped in the same cycle as a pop -> the in-flight word is delivered; no further pops occur until active_in=1.
- Reset asserted one cycle after a pop -> the returned word is discarded; valid_out=0 and count=0 after release.
- With DEST_READER_COUNT_EN defined, 256 words delivered -> count wraps to 0. Without the macro -> count stays 0 throughout.
